// File: rtl/tile_loader.sv
// tile_loader: host-side transmitter that streams one tile of kernel weights,
// input activations and overlap-column activations from a word-addressed
// source memory into the accelerator's kernel memory, input memory and
// overlap cache.
//
// Ports:
//   clk, arst_in          clock, asynchronous active-high reset
//   start                 one-cycle load request, honoured only when idle
//   src_base, kernel_base source region bases, latched at start
//   rows_valid            real rows in the tile (saturates at TILE_H), latched at start
//   busy, done            busy while a tile is in flight; done pulses on return to idle
//   src_re, src_addr      source read request
//   src_data              source read data, one cycle after src_re
//   a_input, b_input      chip write address / data
//   int_mem_we            chip internal-memory write strobe
//   overlap_cache_we      chip overlap-cache write strobe
//   b_zero                chip forces the written activation to zero
//   data_ready            one-cycle pulse once the whole tile is written
//   fsm_done              chip finished computing on the tile
module tile_loader #(
  parameter int unsigned IO_DATA_WIDTH   = 16,
  parameter int unsigned SRC_ADDR_WIDTH  = 20,
  parameter int unsigned TILE_W          = 64,
  parameter int unsigned TILE_H          = 128,
  parameter int unsigned OUT_CH_PER_TILE = 16,
  parameter int unsigned KERNEL_SIZE     = 3
) (
  input  logic                      clk,
  input  logic                      arst_in,
  input  logic                      start,
  input  logic [SRC_ADDR_WIDTH-1:0] src_base,
  input  logic [SRC_ADDR_WIDTH-1:0] kernel_base,
  input  logic [7:0]                rows_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      src_re,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [IO_DATA_WIDTH-1:0]  src_data,
  output logic [15:0]               a_input,
  output logic [IO_DATA_WIDTH-1:0]  b_input,
  output logic                      int_mem_we,
  output logic                      overlap_cache_we,
  output logic                      b_zero,
  output logic                      data_ready,
  input  logic                      fsm_done
);

  localparam int unsigned X_W         = $clog2(TILE_W);
  localparam int unsigned Y_W         = $clog2(TILE_H);
  localparam int unsigned OC_W        = $clog2(OUT_CH_PER_TILE);
  localparam int unsigned K_W         = 2;
  localparam int unsigned KIDX_W      = 1 + 2 * K_W + OC_W;
  localparam int unsigned IIDX_W      = 1 + Y_W + X_W;
  localparam int unsigned OIDX_W      = 1 + Y_W;
  localparam int unsigned IDX_W       = IIDX_W;
  localparam int unsigned ROWS_W      = 8;
  localparam int unsigned CHIP_AW     = 16;
  localparam int unsigned OVL_SRC_OFS = 2 * TILE_W * TILE_H;
  localparam logic [CHIP_AW-1:0] KMEM_SEL = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KERNEL,
    S_INPUT,
    S_OVERLAP,
    S_FLUSH,
    S_SIGNAL,
    S_WAIT_DONE
  } state_t;

  // One chip write beat, carried from the read-issue stage to the write stage
  typedef struct packed {
    logic               int_we;
    logic               ovl_we;
    logic               zero;
    logic [CHIP_AW-1:0] addr;
  } wr_beat_t;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic [SRC_ADDR_WIDTH-1:0] r_src_base, w_src_base_nxt;
  logic [SRC_ADDR_WIDTH-1:0] r_kernel_base, w_kernel_base_nxt;
  logic [ROWS_W-1:0]         r_rows, w_rows_nxt;
  logic                      w_done_nxt;
  logic                      w_data_ready_nxt;

  logic [OC_W-1:0]           w_k_oc;
  logic [K_W-1:0]            w_k_kx;
  logic [K_W-1:0]            w_k_ky;
  logic                      w_k_inch;
  logic                      w_k_oc_last;
  logic                      w_k_kx_last;
  logic                      w_k_ky_last;
  logic                      w_k_last;
  logic [KIDX_W-1:0]         w_k_inc;

  wr_beat_t                  w_iss_nxt, r_iss, r_wr;
  logic                      w_re_nxt, r_src_re;
  logic [SRC_ADDR_WIDTH-1:0] w_addr_nxt, r_src_addr;
  logic [Y_W-1:0]            w_iss_y;
  logic                      w_iss_pad;

  logic                      r_busy;
  logic                      r_done;
  logic                      r_data_ready;

  // Kernel index step: outch innermost, then kx, ky, inch; ky/kx skip index 3
  always_comb begin
    w_k_oc      = r_idx[OC_W-1:0];
    w_k_kx      = r_idx[OC_W +: K_W];
    w_k_ky      = r_idx[OC_W+K_W +: K_W];
    w_k_inch    = r_idx[OC_W+2*K_W];
    w_k_oc_last = (w_k_oc == OC_W'(OUT_CH_PER_TILE - 1));
    w_k_kx_last = (w_k_kx == K_W'(KERNEL_SIZE - 1));
    w_k_ky_last = (w_k_ky == K_W'(KERNEL_SIZE - 1));
    w_k_last    = w_k_oc_last && w_k_kx_last && w_k_ky_last && w_k_inch;
    w_k_inc     = '0;
    w_k_inc[OC_W-1:0]          = w_k_oc_last ? '0 : w_k_oc + OC_W'(1);
    w_k_inc[OC_W +: K_W]       = !w_k_oc_last ? w_k_kx :
                                 (w_k_kx_last ? '0 : w_k_kx + K_W'(1));
    w_k_inc[OC_W+K_W +: K_W]   = !(w_k_oc_last && w_k_kx_last) ? w_k_ky :
                                 (w_k_ky_last ? '0 : w_k_ky + K_W'(1));
    w_k_inc[OC_W+2*K_W]        = w_k_inch ^ (w_k_oc_last && w_k_kx_last && w_k_ky_last);
  end

  // Next-state, index and latched-parameter logic
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_src_base_nxt    = r_src_base;
    w_kernel_base_nxt = r_kernel_base;
    w_rows_nxt        = r_rows;
    w_done_nxt        = 1'b0;
    w_data_ready_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt       = S_KERNEL;
          w_idx_nxt         = '0;
          w_src_base_nxt    = src_base;
          w_kernel_base_nxt = kernel_base;
          w_rows_nxt        = (rows_valid > ROWS_W'(TILE_H)) ? ROWS_W'(TILE_H) : rows_valid;
        end
      end
      S_KERNEL: begin
        if (w_k_last) begin
          w_state_nxt = S_INPUT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = IDX_W'(w_k_inc);
        end
      end
      S_INPUT: begin
        if (r_idx == {IDX_W{1'b1}}) begin
          w_state_nxt = S_OVERLAP;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_OVERLAP: begin
        if (r_idx[OIDX_W-1:0] == {OIDX_W{1'b1}}) begin
          w_state_nxt = S_FLUSH;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_FLUSH:  w_state_nxt = S_SIGNAL;
      S_SIGNAL: begin
        w_state_nxt      = S_WAIT_DONE;
        w_data_ready_nxt = 1'b1;
      end
      S_WAIT_DONE: begin
        if (fsm_done) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read-issue decode for the upcoming cycle; padded rows write zero without a read
  always_comb begin
    w_iss_nxt  = '0;
    w_re_nxt   = 1'b0;
    w_addr_nxt = '0;
    w_iss_y    = '0;
    w_iss_pad  = 1'b0;
    case (w_state_nxt)
      S_KERNEL: begin
        w_iss_nxt.int_we = 1'b1;
        w_iss_nxt.addr   = KMEM_SEL | CHIP_AW'(w_idx_nxt[KIDX_W-1:0]);
        w_re_nxt         = 1'b1;
        w_addr_nxt       = w_kernel_base_nxt + SRC_ADDR_WIDTH'(w_idx_nxt[KIDX_W-1:0]);
      end
      S_INPUT: begin
        w_iss_y          = w_idx_nxt[X_W +: Y_W];
        w_iss_pad        = (ROWS_W'(w_iss_y) >= w_rows_nxt);
        w_iss_nxt.int_we = 1'b1;
        w_iss_nxt.zero   = w_iss_pad;
        w_iss_nxt.addr   = CHIP_AW'(w_idx_nxt);
        w_re_nxt         = !w_iss_pad;
        if (!w_iss_pad) begin
          w_addr_nxt = w_src_base_nxt + SRC_ADDR_WIDTH'(w_idx_nxt);
        end
      end
      S_OVERLAP: begin
        w_iss_y          = w_idx_nxt[Y_W-1:0];
        w_iss_pad        = (ROWS_W'(w_iss_y) >= w_rows_nxt);
        w_iss_nxt.ovl_we = 1'b1;
        w_iss_nxt.zero   = w_iss_pad;
        w_iss_nxt.addr   = CHIP_AW'(w_idx_nxt[OIDX_W-1:0]);
        w_re_nxt         = !w_iss_pad;
        if (!w_iss_pad) begin
          w_addr_nxt = w_src_base_nxt + SRC_ADDR_WIDTH'(OVL_SRC_OFS)
                     + SRC_ADDR_WIDTH'(w_idx_nxt[OIDX_W-1:0]);
        end
      end
      default: ;
    endcase
  end

  // FSM state, counters and latched tile parameters
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_src_base    <= '0;
      r_kernel_base <= '0;
      r_rows        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_data_ready  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_src_base    <= w_src_base_nxt;
      r_kernel_base <= w_kernel_base_nxt;
      r_rows        <= w_rows_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_data_ready  <= w_data_ready_nxt;
    end
  end

  // Two-stage pipeline: read issue, then the write aligned with src_data
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_src_re   <= 1'b0;
      r_src_addr <= '0;
      r_iss      <= '0;
      r_wr       <= '0;
    end else begin
      r_src_re   <= w_re_nxt;
      r_src_addr <= w_addr_nxt;
      r_iss      <= w_iss_nxt;
      r_wr       <= r_iss;
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign data_ready       = r_data_ready;
  assign src_re           = r_src_re;
  assign src_addr         = r_src_addr;
  assign a_input          = r_wr.addr;
  assign int_mem_we       = r_wr.int_we;
  assign overlap_cache_we = r_wr.ovl_we;
  assign b_zero           = r_wr.zero;
  // Data passes straight through from the source; padded beats are forced to zero
  assign b_input          = r_wr.zero ? '0 : src_data;

endmodule
